// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the issue scoreboard: register index width,
// register count and the issue-slot FSM state encoding.
package issue_scoreboard_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FULL     = 2'd1,
    FLUSHING = 2'd2
  } issue_state_t;

endpackage

// File: rtl/issue_scoreboard_bits.sv
// Pending-destination bitmap (scoreboard_bits): one bit per architectural register,
// set on issue of a writer, cleared on writeback, wiped on flush. x0 is never tracked.
module scoreboard_bits
  import issue_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                set_en_i,
  input  reg_idx_t            set_idx_i,
  input  logic                clr_en_i,
  input  reg_idx_t            clr_idx_i,
  input  logic                flush_i,
  output logic [NUM_REGS-1:0] pending_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;

  // Set and clear never target the same index: a writer only issues when its rd is idle.
  always_comb begin
    pending_d = pending_q;
    if (flush_i) begin
      pending_d = '0;
    end else begin
      if (clr_en_i) pending_d[clr_idx_i] = 1'b0;
      if (set_en_i) pending_d[set_idx_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending_q <= '0;
    else          pending_q <= pending_d;
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/issue_scoreboard.sv
// Register-hazard issue scoreboard: holds one decoded instruction in an issue slot
// and stalls decode on RAW/WAW hazards or a full in-flight budget.
// Optional stall counter enabled by defining ISSUE_STALL_CNT_EN.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = 8,
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                dec_valid,
  output logic                dec_ready,
  input  reg_idx_t            dec_rs1,
  input  reg_idx_t            dec_rs2,
  input  reg_idx_t            dec_rd,
  input  logic                dec_en_rs1,
  input  logic                dec_en_rs2,
  input  logic                dec_en_rd,
  output logic                iss_valid,
  input  logic                iss_ready,
  output reg_idx_t            iss_rs1,
  output reg_idx_t            iss_rs2,
  output reg_idx_t            iss_rd,
  output logic                iss_en_rd,
  input  logic                wb_valid,
  input  reg_idx_t            wb_rd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy,
  output logic [CNT_W-1:0]    inflight,
  output logic [31:0]         stall_cnt,
  output issue_state_t        dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // valid never waits on ready, and a held issue slot stays stable until taken.
  issue_state_t        state_q;
  logic                iss_valid_q, iss_en_rd_q;
  reg_idx_t            iss_rs1_q, iss_rs2_q, iss_rd_q;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [NUM_REGS-1:0] pending;
  logic                hazard, accept, set_en, wb_hit;

  assign hazard = (dec_en_rs1 & pending[dec_rs1]) | (dec_en_rs2 & pending[dec_rs2]) |
                  (dec_en_rd & pending[dec_rd]) | (inflight_q == CNT_W'(MAX_INFLIGHT));

  assign dec_ready = reset_n & ~hazard & ~flush & (state_q != FLUSHING) &
                     (~iss_valid_q | iss_ready);
  assign accept    = dec_valid & dec_ready;
  assign set_en    = accept & dec_en_rd & (dec_rd != '0);
  assign wb_hit    = wb_valid & (wb_rd != '0) & pending[wb_rd] & ~flush;

  scoreboard_bits u_bits (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_en_i  (set_en),
    .set_idx_i (dec_rd),
    .clr_en_i  (wb_hit),
    .clr_idx_i (wb_rd),
    .flush_i   (flush),
    .pending_o (pending)
  );

  always_comb begin
    inflight_d = inflight_q;
    if (flush)                inflight_d = '0;
    else if (set_en & ~wb_hit) inflight_d = inflight_q + CNT_W'(1);
    else if (~set_en & wb_hit) inflight_d = inflight_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) inflight_q <= '0;
    else          inflight_q <= inflight_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      iss_valid_q <= 1'b0;
      iss_rs1_q   <= '0;
      iss_rs2_q   <= '0;
      iss_rd_q    <= '0;
      iss_en_rd_q <= 1'b0;
    end else if (flush) begin
      state_q     <= FLUSHING;
      iss_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY, FULL: begin
          if (accept) begin
            state_q     <= FULL;
            iss_valid_q <= 1'b1;
            iss_rs1_q   <= dec_rs1;
            iss_rs2_q   <= dec_rs2;
            iss_rd_q    <= dec_rd;
            iss_en_rd_q <= dec_en_rd & (dec_rd != '0);
          end else if (iss_valid_q & iss_ready) begin
            state_q     <= EMPTY;
            iss_valid_q <= 1'b0;
          end
        end
        FLUSHING: state_q <= EMPTY;
        default:  state_q <= EMPTY;
      endcase
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (dec_valid & hazard & ~flush & (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

  assign iss_valid = iss_valid_q;
  assign iss_rs1   = iss_rs1_q;
  assign iss_rs2   = iss_rs2_q;
  assign iss_rd    = iss_rd_q;
  assign iss_en_rd = iss_en_rd_q;
  assign busy      = pending;
  assign inflight  = inflight_q;
  assign dbg_state = state_q;

endmodule
